// File: rtl/regfile_wb_buffer.sv
// Writeback buffer in front of the register file write port.
// It queues pending writes in order and forwards the youngest pending data to operand reads.
module regfile_wb_buffer #(
   parameter int DEPTH = 4,
   parameter int AW    = 6,
   parameter int DW    = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   input  logic [AW-1:0]              in_addr,
   input  logic [DW-1:0]              in_data,
   output logic                       in_ready,
   input  logic                       flush,
   input  logic                       drain_en,
   output logic                       rf_we,
   output logic [AW-1:0]              rf_a3,
   output logic [DW-1:0]              rf_wd3,
   input  logic [AW-1:0]              fa1,
   input  logic [AW-1:0]              fa2,
   output logic                       fhit1,
   output logic                       fhit2,
   output logic [DW-1:0]              fdata1,
   output logic [DW-1:0]              fdata2,
   output logic [$clog2(DEPTH):0]     count
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wb_ent_t;

   wb_ent_t          mem [DEPTH];
   logic [DEPTH-1:0] vld;
   logic [PW-1:0]    wp;
   logic [PW-1:0]    rp;
   logic [CW-1:0]    cnt;
   logic             push;
   logic             empty;

   assign empty    = (cnt == '0);
   assign in_ready = (cnt != CW'(DEPTH));
   assign push     = in_valid && in_ready && !flush;
   assign rf_we    = !empty && drain_en && !flush;
   assign rf_a3    = empty ? '0 : mem[rp].addr;
   assign rf_wd3   = empty ? '0 : mem[rp].data;
   assign count    = cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wp  <= '0;
         rp  <= '0;
         cnt <= '0;
         vld <= '0;
      end else if (flush) begin
         wp  <= '0;
         rp  <= '0;
         cnt <= '0;
         vld <= '0;
      end else begin
         if (push) begin
            wp      <= wp + 1'b1;
            vld[wp] <= 1'b1;
         end
         if (rf_we) begin
            rp      <= rp + 1'b1;
            vld[rp] <= 1'b0;
         end
         unique case ({push, rf_we})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   // Payload needs no reset; valid bits gate every use of it.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wp] <= '{addr: in_addr, data: in_data};
      end
   end

   // Walk oldest to youngest so the last match is the youngest.
   always_comb begin
      logic [PW-1:0] idx;
      fhit1  = 1'b0;
      fhit2  = 1'b0;
      fdata1 = '0;
      fdata2 = '0;
      idx    = rp;
      for (int k = 0; k < DEPTH; k++) begin
         if (vld[idx] && mem[idx].addr == fa1) begin
            fhit1  = 1'b1;
            fdata1 = mem[idx].data;
         end
         if (vld[idx] && mem[idx].addr == fa2) begin
            fhit2  = 1'b1;
            fdata2 = mem[idx].data;
         end
         idx = idx + 1'b1;
      end
   end

   a_cnt_range: assert property (
      @(posedge clk) disable iff (rst) cnt <= CW'(DEPTH)
   );

endmodule

// File: doc/regfile_wb_buffer.md
Name: regfile_wb_buffer

Overview:
Writer-side front end for the register file write port (we3/a3/wd3). It accepts writeback requests from the execute/memory stages through a valid/ready handshake. Requests are queued in a small FIFO and drained into the register file at one write per cycle whenever the drain slot is enabled. Two read-address lookups forward still-pending data, so operand reads never return stale register contents.

Parameters:
DEPTH, 4, number of pending-write entries (power of two, >=2)
AW, 6, register address width (matches register file a1/a2/a3)
DW, 32, register data width (matches register file wd3/out1/out2)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset; clears all state immediately
in_valid  input  1  writeback request present
in_addr  input  AW  destination register address
in_data  input  DW  writeback data
in_ready  output  1  buffer can accept a request this cycle
flush  input  1  synchronous discard of all pending entries
drain_en  input  1  register file write slot available this cycle
rf_we  output  1  to register file we3
rf_a3  output  AW  to register file a3
rf_wd3  output  DW  to register file wd3
fa1  input  AW  forwarding lookup address, port 1 (tied to a1)
fa2  input  AW  forwarding lookup address, port 2 (tied to a2)
fhit1  output  1  pending write to fa1 exists
fhit2  output  1  pending write to fa2 exists
fdata1  output  DW  youngest pending data for fa1, 0 when no hit
fdata2  output  DW  youngest pending data for fa2, 0 when no hit
count  output  clog2(DEPTH)+1  number of pending entries

Behaviour:
- Storage: circular FIFO of DEPTH {addr, data} entries with a valid bit per entry. Write pointer, read pointer and count are held in registers.
- Reset (async, rst=1): pointers=0, count=0, all valid bits=0. Outputs: in_ready=1, rf_we=0, rf_a3=0, rf_wd3=0, fhit1/2=0, fdata1/2=0. Entries pending when reset hits are lost.
- in_ready = (count != DEPTH). This is combinational from count and does not depend on drain_en in the same cycle, so there is no full-bypass path.
- Push: occurs when in_valid && in_ready && !flush. The entry is stored at the write pointer on the edge and becomes visible the following cycle.
- Drain: rf_we = (count != 0) && drain_en && !flush. rf_a3 and rf_wd3 show the head entry combinationally and read 0 when count == 0. On an edge with rf_we=1 the head is popped and the read pointer advances.
- Latency: a request accepted at edge N is first eligible for rf_we in cycle N+1. The minimum accept-to-register-file-write time is 2 edges.
- Simultaneous push and pop: both happen, count is unchanged. This is legal at count==DEPTH only in the sense that no push occurs, since in_ready=0.
- Pointer wrap: both pointers wrap modulo DEPTH with no gaps.
- Order: drain is strict FIFO. Multiple pending writes to the same address are kept and drained in arrival order, so the final register value is the youngest.
- flush=1: on the next edge count=0 and all valid bits=0. Flush takes precedence over push and pop, and rf_we is forced to 0 in the flush cycle.
- Forwarding (combinational): search all valid entries, including the head being drained this cycle, for addr==faN.
  - The youngest match (closest to the write pointer) wins.
  - fhitN=1 with fdataN=that data on a match; otherwise fhitN=0 and fdataN=0.
  - The in-flight in_* request is not forwarded.
- Address 0 is treated like any other address; any r0 policy belongs to the register file.
- Verification assertion: count never exceeds DEPTH and never underflows.

Test Plan:
1. Reset then idle: rst=1 for 1 cycle -> in_ready=1, rf_we=0, count=0, fhit1=fhit2=0.
2. Single write: push {a=1, d=23} with drain_en=0, then 1 cycle -> count=1, fhit1=1, fdata1=23 for fa1=1. Set drain_en=1 -> rf_we=1, rf_a3=1, rf_wd3=23 for one cycle, then count=0.
3. Fill and backpressure: drain_en=0, push {2,5},{3,6},{4,7},{5,8} -> count=4, in_ready=0. A 5th request with in_valid=1 is not accepted. drain_en=1 -> addresses 2,3,4,5 drain on consecutive cycles with data 5,6,7,8.
4. Same-address forwarding: push {2,5} then {2,9}, drain_en=0 -> fa2=2 gives fhit2=1, fdata2=9. Drain one entry -> fdata2 still 9. Drain second -> fhit2=0.
5. Simultaneous push/pop plus wrap: keep count=2 with continuous push+pop for 10 cycles (addresses 1..10) -> count stays 2, drain order is exactly 1..10 across pointer wrap.
6. Flush and mid-operation reset: with 3 entries pending, flush=1 together with in_valid=1 -> count=0, new request dropped, rf_we=0. Refill 2 entries, assert rst asynchronously mid-cycle -> count=0 and rf_we=0 immediately, before the next clock edge.
